lstm_cell_update: RTL and testbench

- Gate-activation and cell-state stage, directly downstream of the four ConcatMultAdd pre-activation units (input, forget, output, candidate gates).
- Applies hard sigmoid / hard tanh, updates the persistent cell state c, and produces h.
- Uses a valid/ready handshake and a multi-cycle FSM.
- All data is signed fixed point, Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH; default Q8.8, where 1.0 = 256.

---
 rtl/lstm_cell_update.sv | 122 ++++++++++++
 tb/tb_lstm_cell_update.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lstm_cell_update.sv
// lstm_cell_update: hard sigmoid/tanh gate activation, cell-state update and hidden output.
// Define LSTM_CELL_SAT_EN to saturate the cell-state sum; by default it wraps.
module lstm_cell_update #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] zi,
  input  logic signed [DATA_WIDTH-1:0] zf,
  input  logic signed [DATA_WIDTH-1:0] zo,
  input  logic signed [DATA_WIDTH-1:0] zg,
  input  logic                         c_load,
  input  logic signed [DATA_WIDTH-1:0] c_load_val,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] h_out,
  output logic signed [DATA_WIDTH-1:0] c_out
);
  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;
  localparam logic signed [W-1:0] ONE = W'(1 << FRACT_WIDTH);

  typedef enum logic [2:0] {IDLE, ACT, MUL, SUM, OUTM, DONE} state_t;

  function automatic logic signed [W-1:0] sig_h(input logic signed [W-1:0] x);
    logic signed [W-1:0] t;
    t = (x >>> 2) + (ONE >>> 1);
    return t[W-1] ? '0 : (t > ONE ? ONE : t);
  endfunction

  function automatic logic signed [W-1:0] tanh_h(input logic signed [W-1:0] x);
    return x < -ONE ? -ONE : (x > ONE ? ONE : x);
  endfunction

  function automatic logic signed [W-1:0] mul(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
    logic signed [W2-1:0] p;
    p = W2'(a) * W2'(b);
    return W'(p >>> FRACT_WIDTH);
  endfunction

  state_t state_q, state_d;
  logic signed [W-1:0] zi_q, zf_q, zo_q, zg_q;
  logic signed [W-1:0] si_q, sf_q, so_q, tg_q;
  logic signed [W-1:0] pf_q, pi_q, tc_q;
  logic signed [W-1:0] c_q, h_q, co_q;
  logic signed [W-1:0] s_red;

`ifdef LSTM_CELL_SAT_EN
  logic signed [W:0] s;
  assign s     = (W + 1)'(pf_q) + (W + 1)'(pi_q);
  // overflow shows as the two top bits of the widened sum disagreeing
  assign s_red = s[W] != s[W-1] ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
`else
  assign s_red = pf_q + pi_q;
`endif

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign h_out     = h_q;
  assign c_out     = co_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? ACT : IDLE;
      ACT:     state_d = MUL;
      MUL:     state_d = SUM;
      SUM:     state_d = OUTM;
      OUTM:    state_d = DONE;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q  <= '0;
      h_q  <= '0;
      co_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c_load) c_q <= c_load_val;
          if (in_valid) begin
            zi_q <= zi;
            zf_q <= zf;
            zo_q <= zo;
            zg_q <= zg;
          end
        end
        ACT: begin
          si_q <= sig_h(zi_q);
          sf_q <= sig_h(zf_q);
          so_q <= sig_h(zo_q);
          tg_q <= tanh_h(zg_q);
        end
        MUL: begin
          pf_q <= mul(sf_q, c_q);
          pi_q <= mul(si_q, tg_q);
        end
        SUM: begin
          c_q  <= s_red;
          tc_q <= tanh_h(s_red);
        end
        OUTM: begin
          h_q  <= mul(so_q, tc_q);
          co_q <= c_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_cell_update.sv
// tb_lstm_cell_update: directed literal checks plus randomized traffic against a step-level model.
module tb_lstm_cell_update;
  logic clk = 0, rst = 1, in_valid = 0, c_load = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic signed [15:0] zi = 0, zf = 0, zo = 0, zg = 0, c_load_val = 0, h_out, c_out;
  int checks = 0, errors = 0;

  lstm_cell_update #(.DATA_WIDTH(16), .FRACT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .zi(zi), .zf(zf), .zo(zo), .zg(zg), .c_load(c_load), .c_load_val(c_load_val),
    .out_valid(out_valid), .out_ready(out_ready), .h_out(h_out), .c_out(c_out)
  );

  always #5 clk = ~clk;

  function automatic int sg(input int x);
    int t;
    t = (x >>> 2) + 128;
    return t < 0 ? 0 : (t > 256 ? 256 : t);
  endfunction
  function automatic int th(input int x);
    return x < -256 ? -256 : (x > 256 ? 256 : x);
  endfunction
  function automatic int ml(input int a, input int b);
    return int'(shortint'((a * b) >>> 8));
  endfunction
  function automatic int red(input int s);
`ifdef LSTM_CELL_SAT_EN
    return s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
`else
    return int'(shortint'(s));
`endif
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // model: cell value, cycles since acceptance (0 idle, 5 holding result), pending and shown results
  bit armed = 0;
  int mc = 0, ph = 0, pc = 0, phv = 0, mh = 0, mco = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      armed = 1; mc = 0; ph = 0; mh = 0; mco = 0;
    end else if (armed) begin
      if (ph == 0) begin
        if (c_load) mc = int'(c_load_val);
        if (in_valid) begin
          mc  = red(ml(sg(int'(zf)), mc) + ml(sg(int'(zi)), th(int'(zg))));
          pc  = mc;
          phv = ml(sg(int'(zo)), th(mc));
          ph  = 1;
        end
      end else if (ph < 4) ph++;
      else if (ph == 4) begin
        mh = phv; mco = pc; ph = 5;
      end else if (out_ready) ph = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("in_ready", int'(in_ready), int'(ph == 0));
      chk("out_valid", int'(out_valid), int'(ph == 5));
      chk("h_out", int'(h_out), mh);
      chk("c_out", int'(c_out), mco);
    end
  end

  task automatic drive(input int a, input int b, input int c, input int d, input bit ld, input int lv);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", int'(in_ready), 1);
    zi = 16'(a); zf = 16'(b); zo = 16'(c); zg = 16'(d);
    c_load = ld; c_load_val = 16'(lv); in_valid = 1;
    @(negedge clk);
    in_valid = 0; c_load = 0;
  endtask

  task automatic result(input string nm, input int ec, input int eh);
    int n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, 4);
    chk({nm, "_c"}, int'(c_out), ec);
    chk({nm, "_h"}, int'(h_out), eh);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_h", int'(h_out), 0);
    drive(0, 0, 0, 256, 0, 0);     result("t1", 128, 64);
    @(negedge clk);
    drive(0, 0, 0, 256, 0, 0);     result("t2a", 192, 96);
    @(negedge clk);
    c_load = 1; c_load_val = 0;    @(negedge clk); c_load = 0;
    drive(0, 0, 0, 256, 0, 0);     result("t2b", 128, 64);
    @(negedge clk);
`ifdef LSTM_CELL_SAT_EN
    drive(2048, 2048, 2048, 256, 1, 32512); result("t3", 32767, 256);
`else
    drive(2048, 2048, 2048, 256, 1, 32512); result("t3", -32768, -256);
`endif
    @(negedge clk);
    out_ready = 0;
    drive(0, 0, 0, 256, 1, 0);     result("t4", 128, 64);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; zi = 16'(i * 100); zg = 16'(i * 50);
      @(negedge clk);
      chk("t4_hold_ready", int'(in_ready), 0);
      chk("t4_hold_c", int'(c_out), 128);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("t4_release", int'(in_ready), 1);
    drive(0, 0, 0, 0, 1, 512);     result("t5", 256, 128);
    @(negedge clk);
    drive(0, 0, 0, 256, 1, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_c", int'(c_out), 0);
    chk("t6_h", int'(h_out), 0);
    chk("t6_ready", int'(in_ready), 1);
    drive(0, 0, 0, 256, 0, 0);     result("t6_after", 128, 64);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      zi = 16'($urandom); zf = 16'($urandom_range(0, 4095) - 2048);
      zo = 16'($urandom); zg = 16'($urandom_range(0, 1023) - 512);
      c_load = $urandom_range(0, 7) == 0;
      c_load_val = 16'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 299) == 0;
    end
    @(negedge clk);
    rst = 0; in_valid = 0; c_load = 0; out_ready = 1;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
